// File: rtl/spi_pwm_ctrl_n.sv
// -----------------------------------------------------------------------------
// spi_pwm_ctrl_n
// SPI-configured multi-channel PWM controller with register read-back.
//
// A mode-0 SPI slave writes and reads an 8-bit register file. The registers
// drive NUM_CH PWM channels that share one prescaled 8-bit period counter.
// Each channel has per-channel output and PWM enables. Its duty cycle is
// double-buffered so that a new duty only takes effect at a period boundary.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   sclk       SPI clock (asynchronous, mode 0, at most clk/4)
//   copi       SPI data in (asynchronous)
//   ncs        SPI chip select, active low (asynchronous)
//   cipo       SPI read data, MSB first, driven during the data byte
//   cipo_oe    high while the synchronised ncs is low
//   out        channel outputs, registered
//   frame_err  one-cycle pulse on an aborted or over-length frame
// -----------------------------------------------------------------------------
module spi_pwm_ctrl_n #(
    parameter int         NUM_CH       = 16,
    parameter int         SYNC_STAGES  = 2,
    parameter logic [7:0] PRESCALE_RST = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              copi,
    input  logic              ncs,
    output logic              cipo,
    output logic              cipo_oe,
    output logic [NUM_CH-1:0] out,
    output logic              frame_err
);
    localparam int NUM_BYTES = NUM_CH / 8;
    localparam int LAST      = SYNC_STAGES - 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} spi_state_t;

    // ---------------- input synchronisers ----------------
    // The ncs chain resets to 0 (selected). If reset lands mid-frame, this
    // means no ncs fall is seen afterwards, so the frame is dropped silently.
    logic [SYNC_STAGES-1:0] sclk_sync_reg, copi_sync_reg, ncs_sync_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_reg <= '0;
            copi_sync_reg <= '0;
            ncs_sync_reg  <= '0;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
            copi_sync_reg <= {copi_sync_reg[SYNC_STAGES-2:0], copi};
            ncs_sync_reg  <= {ncs_sync_reg[SYNC_STAGES-2:0], ncs};
        end
    end

    logic sclk_rise, sclk_fall, ncs_rise, ncs_fall, copi_bit;
    assign sclk_rise = sclk_sync_reg[LAST-1] & ~sclk_sync_reg[LAST];
    assign sclk_fall = ~sclk_sync_reg[LAST-1] & sclk_sync_reg[LAST];
    assign ncs_rise  = ncs_sync_reg[LAST-1] & ~ncs_sync_reg[LAST];
    assign ncs_fall  = ~ncs_sync_reg[LAST-1] & ncs_sync_reg[LAST];
    // copi is held stable around the sclk rise, so the oldest stage is safe to use.
    assign copi_bit  = copi_sync_reg[LAST];

    // ---------------- SPI frame FSM ----------------
    spi_state_t  state_reg;
    logic [4:0]  bit_cnt_reg;
    logic [15:0] shift_reg;
    logic [7:0]  rd_shift_reg;
    logic        cipo_reg, cipo_oe_reg, frame_err_reg;
    logic [15:0] shift_next;
    logic [6:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        wr_commit;
    logic [6:0]  waddr;
    logic [7:0]  wdata;

    assign shift_next = {shift_reg[14:0], copi_bit};
    // On the 8th rising edge the address byte completes with the bit arriving now.
    assign rd_addr    = {shift_reg[5:0], copi_bit};
    assign waddr      = shift_reg[14:8];
    assign wdata      = shift_reg[7:0];
    assign wr_commit  = ncs_rise && (state_reg == DONE) && (bit_cnt_reg == 5'd16)
                        && shift_reg[15];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            rd_shift_reg  <= '0;
            cipo_reg      <= 1'b0;
            cipo_oe_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            frame_err_reg <= 1'b0;
            cipo_oe_reg   <= ~ncs_sync_reg[LAST];
            if (ncs_rise) begin
                // A short frame is flagged. A complete one is committed via wr_commit.
                if (state_reg != IDLE && !(state_reg == DONE && bit_cnt_reg == 5'd16))
                    frame_err_reg <= 1'b1;
                state_reg <= IDLE;
                cipo_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (ncs_fall) begin
                            state_reg   <= ADDR;
                            bit_cnt_reg <= '0;
                        end
                    end
                    ADDR: begin
                        if (sclk_rise) begin
                            shift_reg   <= shift_next;
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                            if (bit_cnt_reg == 5'd7) begin
                                state_reg    <= DATA;
                                rd_shift_reg <= rd_data;
                            end
                        end
                    end
                    DATA: begin
                        if (sclk_rise) begin
                            shift_reg   <= shift_next;
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                            if (bit_cnt_reg == 5'd15) begin
                                state_reg <= DONE;
                                cipo_reg  <= 1'b0;
                            end
                        end else if (sclk_fall) begin
                            cipo_reg     <= rd_shift_reg[7];
                            rd_shift_reg <= {rd_shift_reg[6:0], 1'b0};
                        end
                    end
                    DONE: begin
                        // A 17th rising edge kills the frame. The later ncs rise is then silent.
                        if (sclk_rise) begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= IDLE;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign cipo      = cipo_reg;
    assign cipo_oe   = cipo_oe_reg;
    assign frame_err = frame_err_reg;

    // ---------------- prescaler and period counter ----------------
    logic [7:0] prescale_reg, presc_cnt_reg, per_cnt_reg;
    logic       tick, wrap;

    assign tick = (presc_cnt_reg == prescale_reg);
    assign wrap = tick && (per_cnt_reg == 8'hFF);

    always_ff @(posedge clk) begin
        if (rst) begin
            prescale_reg  <= PRESCALE_RST;
            presc_cnt_reg <= '0;
            per_cnt_reg   <= '0;
        end else begin
            if (wr_commit && waddr == 7'h08) begin
                prescale_reg  <= wdata;
                presc_cnt_reg <= '0;
            end else if (tick) begin
                presc_cnt_reg <= '0;
            end else begin
                presc_cnt_reg <= presc_cnt_reg + 8'd1;
            end
            if (tick)
                per_cnt_reg <= per_cnt_reg + 8'd1;
        end
    end

    // ---------------- register bank and channels ----------------
    logic [NUM_CH-1:0] en_out, en_pwm;
    logic [7:0]        duty_sh [NUM_CH];
    genvar gi;

    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_byte
            logic [7:0] en_out_b_reg, en_pwm_b_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    en_out_b_reg <= '0;
                    en_pwm_b_reg <= '0;
                end else if (wr_commit) begin
                    if (waddr == 7'(gi))     en_out_b_reg <= wdata;
                    if (waddr == 7'(4 + gi)) en_pwm_b_reg <= wdata;
                end
            end
            assign en_out[gi*8 +: 8] = en_out_b_reg;
            assign en_pwm[gi*8 +: 8] = en_pwm_b_reg;
        end

        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [7:0] duty_sh_reg, duty_act_reg, duty_sh_next;
            logic       pwm, out_reg;

            // The active duty loads the post-commit shadow value. A write that
            // coincides with the wrap is therefore picked up at that wrap.
            assign duty_sh_next = (wr_commit && waddr == 7'(16 + gi)) ? wdata : duty_sh_reg;
            assign pwm          = (per_cnt_reg < duty_act_reg) | (duty_act_reg == 8'hFF);

            always_ff @(posedge clk) begin
                if (rst) begin
                    duty_sh_reg  <= '0;
                    duty_act_reg <= '0;
                    out_reg      <= 1'b0;
                end else begin
                    duty_sh_reg <= duty_sh_next;
                    if (wrap)
                        duty_act_reg <= duty_sh_next;
                    out_reg <= en_out[gi] & (en_pwm[gi] ? pwm : 1'b1);
                end
            end

            assign duty_sh[gi] = duty_sh_reg;
            assign out[gi]     = out_reg;
        end
    endgenerate

    // Read mux. The enables are zero-padded so bytes beyond NUM_CH read 0x00.
    logic [31:0] en_out_pad, en_pwm_pad;
    assign en_out_pad = 32'(en_out);
    assign en_pwm_pad = 32'(en_pwm);

    always_comb begin
        rd_data = 8'h00;
        if (rd_addr[6:2] == 5'd0) begin
            rd_data = en_out_pad[{rd_addr[1:0], 3'b000} +: 8];
        end else if (rd_addr[6:2] == 5'd1) begin
            rd_data = en_pwm_pad[{rd_addr[1:0], 3'b000} +: 8];
        end else if (rd_addr == 7'h08) begin
            rd_data = prescale_reg;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (rd_addr == 7'(16 + i))
                    rd_data = duty_sh[i];
        end
    end

endmodule

// File: tb/tb_spi_pwm_ctrl_n.sv
// -----------------------------------------------------------------------------
// tb_spi_pwm_ctrl_n
// Directed bench for spi_pwm_ctrl_n (NUM_CH=16, SYNC_STAGES=2, PRESCALE_RST=0).
// SPI frames run at sclk = clk/8. Every expected value is hand-computed.
// -----------------------------------------------------------------------------
module tb_spi_pwm_ctrl_n;
    logic        clk = 1'b0;
    logic        rst;
    logic        sclk, copi, ncs;
    logic        cipo, cipo_oe, frame_err;
    logic [15:0] ch_out;

    int checks   = 0;
    int failures = 0;
    int ferr_cnt = 0;

    spi_pwm_ctrl_n #(
        .NUM_CH      (16),
        .SYNC_STAGES (2),
        .PRESCALE_RST(8'h00)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .copi     (copi),
        .ncs      (ncs),
        .cipo     (cipo),
        .cipo_oe  (cipo_oe),
        .out      (ch_out),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && frame_err)
            ferr_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Full or partial SPI frame. Bits past 16 shift in zeros. rx holds cipo
    // sampled just before each rising edge, MSB first.
    task automatic spi_xfer(input logic [15:0] word, input int nbits, output logic [15:0] rx);
        int idx;
        rx = '0;
        @(negedge clk);
        ncs = 1'b0;
        repeat (4) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            idx  = (b < 16) ? 15 - b : 0;
            copi = (b < 16) ? word[idx] : 1'b0;
            repeat (4) @(negedge clk);
            if (b < 16) rx[idx] = cipo;
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        ncs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_wr(input logic [6:0] addr, input logic [7:0] data);
        logic [15:0] rx;
        spi_xfer({1'b1, addr, data}, 16, rx);
    endtask

    task automatic spi_rd(input logic [6:0] addr, output logic [7:0] data);
        logic [15:0] rx;
        spi_xfer({1'b0, addr, 8'h00}, 16, rx);
        data = rx[7:0];
    endtask

    // Returns at the first sample where out[3] has just gone high.
    task automatic wait_rise(output logic ok);
        logic prev;
        prev = ch_out[3];
        ok   = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            if (ch_out[3] && !prev) ok = 1'b1;
            prev = ch_out[3];
        end
    endtask

    // Period and high time of out[3], measured between consecutive rising edges.
    task automatic measure(output int per, output int hi);
        logic ok, prev, done;
        per = 0;
        hi  = 0;
        wait_rise(ok);
        if (ok) begin
            per  = 1;
            hi   = 1;
            prev = 1'b1;
            done = 1'b0;
            for (int i = 0; i < 4000 && !done; i++) begin
                @(negedge clk);
                if (ch_out[3] && !prev) begin
                    done = 1'b1;
                end else begin
                    per++;
                    if (ch_out[3]) hi++;
                end
                prev = ch_out[3];
            end
            if (!done) per = 0;
        end
    endtask

    logic [7:0]  rd;
    logic [15:0] rx16;
    int          per, hi, h1, h2, ferr_base;
    logic        ok;

    initial begin
        rst  = 1'b1;
        sclk = 1'b0;
        copi = 1'b0;
        ncs  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out", 32'(ch_out), 32'h0);
        check("rst_cipo", 32'(cipo), 32'h0);
        check("rst_cipo_oe", 32'(cipo_oe), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        spi_rd(7'h08, rd);
        check("rd_prescale_rst", 32'(rd), 32'h00);
        spi_wr(7'h00, 8'h0F);
        check("wr_en_out_0f", 32'(ch_out), 32'h000F);

        // Reset in the middle of a frame: 5 bits, then 2 cycles of rst.
        @(negedge clk);
        ncs = 1'b0;
        for (int b = 0; b < 5; b++) begin
            copi = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_out", 32'(ch_out), 32'h0);
        check("midrst_cipo_oe", 32'(cipo_oe), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("postrst_cipo_oe_low_ncs", 32'(cipo_oe), 32'h1);
        ferr_base = ferr_cnt;
        ncs = 1'b1;
        repeat (8) @(negedge clk);
        check("midrst_abort_silent", 32'(ferr_cnt), 32'(ferr_base));
        spi_wr(7'h00, 8'h01);
        check("postrst_wr_out0", 32'(ch_out), 32'h0001);

        // Static enables.
        spi_wr(7'h00, 8'hFF);
        spi_wr(7'h04, 8'h00);
        check("static_all_on", 32'(ch_out), 32'h00FF);
        spi_wr(7'h04, 8'h01);
        check("static_pwm_duty0", 32'(ch_out), 32'h00FE);

        // PWM on channel 3 only. duty[3] starts at 0.
        spi_wr(7'h04, 8'h08);
        check("pwm3_duty0_low", 32'(ch_out), 32'h00F7);
        spi_wr(7'h13, 8'h40);
        measure(per, hi);
        check("pwm_p0_period", 32'(per), 32'd256);
        check("pwm_p0_high", 32'(hi), 32'd64);
        spi_wr(7'h08, 8'h03);
        spi_rd(7'h08, rd);
        check("rd_prescale", 32'(rd), 32'h03);
        measure(per, hi);
        check("pwm_p3_period", 32'(per), 32'd1024);
        check("pwm_p3_high", 32'(hi), 32'd256);
        spi_wr(7'h08, 8'h00);

        // Shadowing: the write lands mid-period. The current period keeps 64.
        wait_rise(ok);
        check("shadow_sync", 32'(ok), 32'h1);
        h1 = 0;
        h2 = 0;
        fork
            begin
                if (ch_out[3]) h1++;
                for (int i = 1; i < 256; i++) begin
                    @(negedge clk);
                    if (ch_out[3]) h1++;
                end
                for (int i = 0; i < 256; i++) begin
                    @(negedge clk);
                    if (ch_out[3]) h2++;
                end
            end
            spi_wr(7'h13, 8'hC0);
        join
        check("shadow_cur_high", 32'(h1), 32'd64);
        check("shadow_next_high", 32'(h2), 32'd192);
        measure(per, hi);
        check("shadow_steady_period", 32'(per), 32'd256);
        check("shadow_steady_high", 32'(hi), 32'd192);

        // Read-back.
        spi_wr(7'h12, 8'hA5);
        spi_rd(7'h12, rd);
        check("rd_duty2_a5", 32'(rd), 32'hA5);
        spi_rd(7'h13, rd);
        check("rd_duty3_c0", 32'(rd), 32'hC0);
        spi_rd(7'h7F, rd);
        check("rd_unmapped_7f", 32'(rd), 32'h00);
        spi_rd(7'h04, rd);
        check("rd_en_pwm0", 32'(rd), 32'h08);

        // Bytes beyond NUM_CH: writes are ignored and raise no error.
        ferr_base = ferr_cnt;
        spi_wr(7'h03, 8'hFF);
        spi_rd(7'h03, rd);
        check("rd_en_out3_void", 32'(rd), 32'h00);
        check("good_frames_no_err", 32'(ferr_cnt), 32'(ferr_base));
        check("static_mask", 32'(ch_out & 16'hFFF7), 32'h00F7);

        // Framing errors.
        ferr_base = ferr_cnt;
        spi_xfer(16'h80AA, 12, rx16);
        check("short_frame_err", 32'(ferr_cnt), 32'(ferr_base + 1));
        spi_rd(7'h00, rd);
        check("short_frame_no_wr", 32'(rd), 32'hFF);
        spi_xfer(16'h8055, 17, rx16);
        check("long_frame_err", 32'(ferr_cnt), 32'(ferr_base + 2));
        spi_rd(7'h00, rd);
        check("long_frame_no_wr", 32'(rd), 32'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
